// File: rtl/image_pkg.sv
// Shared definitions for the image ROM, the streamer in front of it and the display stage.
// Holds the default frame geometry, the streamer state encoding and the pixel tag layout.
package image_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;
    localparam int WIDTH_DEF = 8;
    localparam int COORD_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } stream_state_t;

    // Frame-level tag carried next to each pixel by downstream stages; coordinates are
    // sized for the largest supported frame.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               last;
    } pixel_tag_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry synchronous FIFO with occupancy output; push and pop may coincide when full.
// A flush empties it in one cycle without touching the stored words.
module pix_fifo2
    import image_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/image_rom_streamer.sv
// Walks a frame in raster order over a synchronous-read ROM and streams the pixels out
// on valid/ready, tagging each with its column, row and an end-of-frame flag.
module image_rom_streamer
    import image_pkg::*;
#(
    parameter int unsigned       WIDTH  = WIDTH_DEF,
    parameter int unsigned       IMG_W  = IMG_W_DEF,
    parameter int unsigned       IMG_H  = IMG_H_DEF,
    parameter int unsigned       ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic [ADDR_W-1:0]        r_addr,
    input  logic [WIDTH-1:0]         rd,
    output logic [WIDTH-1:0]         m_data,
    output logic [$clog2(IMG_W)-1:0] m_x,
    output logic [$clog2(IMG_H)-1:0] m_y,
    output logic                     m_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    // Tags sized to this frame so every bit stored in the FIFO reaches an output.
    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          last;
    } tag_t;

    localparam int TW = $bits(tag_t);
    localparam int PW = WIDTH + TW;

    stream_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    tag_t              tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;

    logic [1:0]        occ;
    logic [PW-1:0]     fifo_q;
    tag_t              head;
    logic              pop;
    logic              rd_last;
    logic              credit_ok;
    logic              issue;
    logic              abort_hit;

    pix_fifo2 #(
        .DW(PW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(abort_hit),
        .push_i (inflight_q),
        .data_i ({rd, tag_q}),
        .pop_i  (pop),
        .data_o (fifo_q),
        .count_o(occ)
    );

    assign head    = tag_t'(fifo_q[TW-1:0]);
    assign m_data  = fifo_q[PW-1:TW];
    assign m_x     = head.x;
    assign m_y     = head.y;
    assign m_valid = (occ != 2'd0);
    assign m_last  = m_valid && head.last;
    assign r_addr  = addr_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    // A read may only be issued while the FIFO plus the read in flight still leaves a free
    // slot after this cycle's pop, so the two-entry FIFO can never overflow.
    always_comb begin
        pop       = m_valid && m_ready;
        rd_last   = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
        abort_hit = abort && (state_q != IDLE);
        credit_ok = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
        issue     = (state_q == RUN) && !abort && credit_ok;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE:    if (start && !abort) state_d = RUN;
            RUN:     if (issue && rd_last) state_d = DRAIN;
            DRAIN: begin
                if (pop && head.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    // Address and raster position advance together; leaving the frame rewinds both.
    always_comb begin
        addr_d     = addr_q;
        x_d        = x_q;
        y_d        = y_q;
        inflight_d = issue;
        tag_d      = '{x: x_q, y: y_q, last: rd_last};
        if (issue) begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
        if (state_d == IDLE) begin
            addr_d = BASE;
            x_d    = '0;
            y_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= BASE;
            x_q        <= '0;
            y_q        <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_image_rom_streamer.sv
// Bench for image_rom_streamer: a 4x2 instance at 0x100 and a 16x16 instance at 0, each fed by
// a ROM returning addr[7:0], checked every cycle against a frame-level pixel-sequence model.
module tb_image_rom_streamer;

   localparam int NDUT = 2;

   logic clk = 1'b0;
   logic rstN;

   always #5 clk = ~clk;

   logic [NDUT-1:0]       startS, abortS, readyS;
   logic [NDUT-1:0]       mLast, mValid, busyS, doneS;
   logic [NDUT-1:0][31:0] rAddr;
   logic [NDUT-1:0][7:0]  mData, mX, mY;

   int nCompared   = 0;
   int nMismatched = 0;

   function automatic int imgW(input int g);
      return (g == 0) ? 4 : 16;
   endfunction

   function automatic int imgH(input int g);
      return (g == 0) ? 2 : 16;
   endfunction

   function automatic longint baseOf(input int g);
      return (g == 0) ? 64'h100 : 64'h0;
   endfunction

   // Each instance gets its own one-cycle-latency ROM holding value = address[7:0].
   for (genvar g = 0; g < NDUT; g++) begin : gDut
      localparam int W = (g == 0) ? 4 : 16;
      localparam int H = (g == 0) ? 2 : 16;
      localparam logic [31:0] B = (g == 0) ? 32'h100 : 32'h0;

      logic [31:0]          addr;
      logic [7:0]           data;
      logic [7:0]           romData;
      logic [$clog2(W)-1:0] x;
      logic [$clog2(H)-1:0] y;
      logic                 last, valid, busy, done;

      image_rom_streamer #(
         .WIDTH (8),
         .IMG_W (W),
         .IMG_H (H),
         .ADDR_W(32),
         .BASE  (B)
      ) uDut (
         .clk    (clk),
         .rst_n  (rstN),
         .start  (startS[g]),
         .abort  (abortS[g]),
         .r_addr (addr),
         .rd     (romData),
         .m_data (data),
         .m_x    (x),
         .m_y    (y),
         .m_last (last),
         .m_valid(valid),
         .m_ready(readyS[g]),
         .busy   (busy),
         .done   (done)
      );

      always @(posedge clk) romData <= addr[7:0];

      assign rAddr[g]  = addr;
      assign mData[g]  = data;
      assign mX[g]     = 8'(x);
      assign mY[g]     = 8'(y);
      assign mLast[g]  = last;
      assign mValid[g] = valid;
      assign busyS[g]  = busy;
      assign doneS[g]  = done;
   end

   task automatic checkOutput(input string name, input int g, input longint actual, input longint expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, g, actual, expected);
      end
   endtask

   // Model: a frame is the pixel index sequence 0..N-1; pixel i carries ROM[BASE+i], x=i%W,
   // y=i/W and last=(i==N-1). Reads outstanding (address steps minus handshakes) stay <= 2.
   int          expIdx    [NDUT];
   int          issued    [NDUT];
   int          popped    [NDUT];
   int          doneCount [NDUT];
   bit          expBusy   [NDUT];
   bit          expDone   [NDUT];
   bit          holdPrev  [NDUT];
   logic [7:0]  prevData  [NDUT];
   logic [7:0]  prevX     [NDUT];
   logic [7:0]  prevY     [NDUT];
   logic        prevLast  [NDUT];
   logic [31:0] prevAddr  [NDUT];

   initial begin
      for (int g = 0; g < NDUT; g++) doneCount[g] = 0;
   end

   always @(negedge clk) begin
      if (!rstN) begin
         for (int g = 0; g < NDUT; g++) begin
            expIdx[g]   = 0;
            issued[g]   = 0;
            popped[g]   = 0;
            expBusy[g]  = 1'b0;
            expDone[g]  = 1'b0;
            holdPrev[g] = 1'b0;
            prevAddr[g] = 32'(baseOf(g));
         end
      end else begin
         for (int g = 0; g < NDUT; g++) begin
            int n;
            int i;
            bit hs;
            n = imgW(g) * imgH(g);
            i = expIdx[g];

            checkOutput("busy", g, busyS[g], expBusy[g]);
            checkOutput("done", g, doneS[g], expDone[g]);
            if (!expBusy[g]) begin
               checkOutput("idle_valid", g, mValid[g], 0);
               checkOutput("idle_addr", g, rAddr[g], baseOf(g));
            end else begin
               checkOutput("addr_range", g, (longint'(rAddr[g]) - baseOf(g)) > n, 0);
            end
            if (holdPrev[g]) begin
               checkOutput("hold_valid", g, mValid[g], 1);
               checkOutput("hold_data", g, mData[g], prevData[g]);
               checkOutput("hold_x", g, mX[g], prevX[g]);
               checkOutput("hold_y", g, mY[g], prevY[g]);
               checkOutput("hold_last", g, mLast[g], prevLast[g]);
            end
            if (mValid[g]) begin
               checkOutput("pix_data", g, mData[g], (baseOf(g) + i) % 256);
               checkOutput("pix_x", g, mX[g], i % imgW(g));
               checkOutput("pix_y", g, mY[g], i / imgW(g));
               checkOutput("pix_last", g, mLast[g], i == n - 1);
            end
            if (expBusy[g] && (rAddr[g] == prevAddr[g] + 32'd1)) issued[g]++;
            if (expBusy[g]) checkOutput("outstanding_le2", g, (issued[g] - popped[g]) > 2, 0);

            hs = mValid[g] && readyS[g];
            expDone[g] = 1'b0;
            if (expBusy[g] && abortS[g]) begin
               expBusy[g]  = 1'b0;
               expIdx[g]   = 0;
               holdPrev[g] = 1'b0;
            end else if (!expBusy[g]) begin
               holdPrev[g] = 1'b0;
               if (startS[g] && !abortS[g]) begin
                  expBusy[g] = 1'b1;
                  issued[g]  = 0;
                  popped[g]  = 0;
               end
            end else begin
               holdPrev[g] = mValid[g] && !readyS[g];
               if (hs) begin
                  popped[g]++;
                  if (i == n - 1) begin
                     expBusy[g] = 1'b0;
                     expDone[g] = 1'b1;
                     expIdx[g]  = 0;
                     doneCount[g]++;
                  end else begin
                     expIdx[g]++;
                  end
               end
            end
            prevData[g] = mData[g];
            prevX[g]    = mX[g];
            prevY[g]    = mY[g];
            prevLast[g] = mLast[g];
            prevAddr[g] = rAddr[g];
         end
      end
   end

   task automatic applyStimulus(input int g, input bit s, input bit a, input bit r);
      startS[g] = s;
      abortS[g] = a;
      readyS[g] = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseStart(input int g, input bit r);
      applyStimulus(g, 1'b1, 1'b0, r);
      step();
      applyStimulus(g, 1'b0, 1'b0, r);
   endtask

   task automatic waitDone(input int g, input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (doneS[g]) seen = 1'b1;
      end
      checkOutput("done_seen", g, seen, 1);
      step();
   endtask

   task automatic waitPixel(input int g, input int value, input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (mValid[g] && (mData[g] == 8'(value))) seen = 1'b1;
      end
      checkOutput("pixel_seen", g, seen, 1);
   endtask

   // Hand-computed cycle map of the 4x2 frame with m_ready high: cycle k after the start edge.
   task automatic runScenario1();
      applyStimulus(0, 1'b0, 1'b0, 1'b1);
      step();
      pulseStart(0, 1'b1);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k <= 7) checkOutput("s1_addr", 0, rAddr[0], 32'h100 + k);
         checkOutput("s1_valid", 0, mValid[0], (k >= 2) && (k <= 9));
         if ((k >= 2) && (k <= 9)) begin
            checkOutput("s1_data", 0, mData[0], k - 2);
            checkOutput("s1_last", 0, mLast[0], k == 9);
         end
         checkOutput("s1_done", 0, doneS[0], k == 10);
         checkOutput("s1_busy", 0, busyS[0], k <= 9);
      end
      step();
   endtask

   initial begin
      int d0;
      bit seen;

      rstN   = 1'b1;
      startS = '0;
      abortS = '0;
      readyS = '0;
      #2 rstN = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_addr", 0, rAddr[0], 32'h100);
      checkOutput("rst_addr", 1, rAddr[1], 32'h0);
      checkOutput("rst_valid", 0, mValid[0], 0);
      checkOutput("rst_busy", 0, busyS[0], 0);
      checkOutput("rst_done", 0, doneS[0], 0);
      checkOutput("rst_data", 0, mData[0], 0);
      checkOutput("rst_last", 0, mLast[0], 0);
      @(posedge clk);
      #1 rstN = 1'b1;
      step();

      $display("[TB] scenario 1: 4x2 frame, ready high");
      runScenario1();

      $display("[TB] scenario 2: backpressure after first pixel");
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      step();
      pulseStart(0, 1'b0);
      waitPixel(0, 0, 10);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         checkOutput("s2_hold_valid", 0, mValid[0], 1);
         checkOutput("s2_hold_data", 0, mData[0], 0);
         checkOutput("s2_addr_stall", 0, rAddr[0], 32'h102);
      end
      step();
      readyS[0] = 1'b1;
      waitDone(0, 40);
      checkOutput("s2_pixels", 0, popped[0], 8);

      $display("[TB] scenario 3: 16x16 frame, random ready");
      applyStimulus(1, 1'b0, 1'b0, 1'b0);
      step();
      d0 = doneCount[1];
      pulseStart(1, 1'($urandom_range(0, 1)));
      seen = 1'b0;
      for (int c = 0; c < 4000 && !seen; c++) begin
         step();
         readyS[1] = 1'($urandom_range(0, 1));
         if (doneS[1]) seen = 1'b1;
      end
      checkOutput("s3_done_seen", 1, seen, 1);
      repeat (5) step();
      checkOutput("s3_done_once", 1, doneCount[1] - d0, 1);
      checkOutput("s3_pixels", 1, popped[1], 256);

      $display("[TB] scenario 4: restart ignored, abort, abort+start");
      d0 = doneCount[0];
      applyStimulus(0, 1'b0, 1'b0, 1'b1);
      pulseStart(0, 1'b1);
      repeat (3) step();
      pulseStart(0, 1'b1);
      waitDone(0, 40);
      checkOutput("s4_restart_pixels", 0, popped[0], 8);
      checkOutput("s4_restart_done", 0, doneCount[0] - d0, 1);

      d0 = doneCount[0];
      pulseStart(0, 1'b1);
      waitPixel(0, 3, 20);
      @(posedge clk);
      #1 applyStimulus(0, 1'b0, 1'b1, 1'b1);
      step();
      applyStimulus(0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("s4_abort_valid", 0, mValid[0], 0);
      checkOutput("s4_abort_busy", 0, busyS[0], 0);
      checkOutput("s4_abort_addr", 0, rAddr[0], 32'h100);
      repeat (5) begin
         @(negedge clk);
         checkOutput("s4_abort_no_done", 0, doneS[0], 0);
      end
      checkOutput("s4_abort_done_count", 0, doneCount[0] - d0, 0);
      step();
      pulseStart(0, 1'b1);
      waitPixel(0, 0, 10);
      checkOutput("s4_first_x", 0, mX[0], 0);
      checkOutput("s4_first_y", 0, mY[0], 0);
      waitDone(0, 40);

      applyStimulus(0, 1'b1, 1'b1, 1'b1);
      step();
      applyStimulus(0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("s4_abort_wins", 0, busyS[0], 0);
      step();

      $display("[TB] scenario 5: asynchronous reset mid-frame");
      pulseStart(0, 1'b1);
      repeat (4) step();
      #2 rstN = 1'b0;
      #1;
      checkOutput("s5_addr", 0, rAddr[0], 32'h100);
      checkOutput("s5_valid", 0, mValid[0], 0);
      checkOutput("s5_busy", 0, busyS[0], 0);
      checkOutput("s5_done", 0, doneS[0], 0);
      checkOutput("s5_data", 0, mData[0], 0);
      checkOutput("s5_x", 0, mX[0], 0);
      checkOutput("s5_y", 0, mY[0], 0);
      checkOutput("s5_last", 0, mLast[0], 0);
      @(posedge clk);
      #1 rstN = 1'b1;
      repeat (3) step();
      runScenario1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
